// File: rtl/running_sum_window_if.sv
// Sample-in / sum-pair-out handshake bundle for running_sum_window.
// master drives samples and m_ready; slave is the accumulator itself.
interface running_sum_window_if #(
    parameter int WIDTH  = 32,
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [WIDTH-1:0]  m_sum;
    logic [WIDTH-1:0]  m_count;

    modport master (
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_sum,
        input  m_count
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_sum,
        output m_count
    );
endinterface

// File: rtl/running_sum_window.sv
// Sliding-window sum/count accumulator feeding the running-mean divider.
// Optional macro RSUM_PRIME_EN: emit pairs only once the window is full.
module running_sum_window #(
    parameter int WIDTH  = 32,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    running_sum_window_if.slave   bus
);
    localparam int               PTR_W       = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
    localparam logic [WIDTH-1:0] LAST_FILL_W = WIDTH'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] sext(input logic [DATA_W-1:0] d);
        return {{(WIDTH-DATA_W){d[DATA_W-1]}}, d};
    endfunction

    state_t            state_r;
    logic [WIDTH-1:0]  sum_r;
    logic [WIDTH-1:0]  count_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [DATA_W-1:0] buf_r [DEPTH];
    logic              m_valid_r;
    logic [WIDTH-1:0]  m_sum_r;
    logic [WIDTH-1:0]  m_count_r;

    logic              s_ready_s;
    logic              accept_s;
    logic              emit_s;
    logic              reach_full_s;
    logic [WIDTH-1:0]  oldest_s;
    logic [WIDTH-1:0]  sum_next_s;
    logic [WIDTH-1:0]  count_next_s;

    // Next window sum/count, handshake qualification and emit decision
    always_comb begin
        oldest_s     = sext(buf_r[wr_ptr_r]);
        reach_full_s = (state_r != ST_FULL) && (count_r == LAST_FILL_W);
        sum_next_s   = sum_r;
        count_next_s = count_r;
        if (state_r == ST_FULL) begin
            // buf_r[wr_ptr_r] still holds the oldest sample: it is overwritten this edge
            sum_next_s   = sum_r + sext(bus.s_data) - oldest_s;
            count_next_s = count_r;
        end else begin
            sum_next_s   = sum_r + sext(bus.s_data);
            count_next_s = count_r + ONE_W;
        end
`ifdef RSUM_PRIME_EN
        emit_s    = (state_r == ST_FULL) || reach_full_s;
        s_ready_s = !clear && ((state_r != ST_FULL) || !m_valid_r || bus.m_ready);
`else
        emit_s    = 1'b1;
        s_ready_s = !clear && (!m_valid_r || bus.m_ready);
`endif
        accept_s = bus.s_valid && s_ready_s;
    end

    // Window state machine, accumulators and registered output pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_EMPTY;
            sum_r     <= '0;
            count_r   <= '0;
            wr_ptr_r  <= '0;
            m_valid_r <= 1'b0;
            m_sum_r   <= '0;
            m_count_r <= '0;
        end else if (clear) begin
            state_r   <= ST_EMPTY;
            sum_r     <= '0;
            count_r   <= '0;
            wr_ptr_r  <= '0;
            m_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                sum_r    <= sum_next_s;
                count_r  <= count_next_s;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                case (state_r)
                    ST_EMPTY:   state_r <= reach_full_s ? ST_FULL : ST_FILLING;
                    ST_FILLING: state_r <= reach_full_s ? ST_FULL : ST_FILLING;
                    ST_FULL:    state_r <= ST_FULL;
                    default:    state_r <= ST_EMPTY;
                endcase
            end
            if (accept_s && emit_s) begin
                m_valid_r <= 1'b1;
                m_sum_r   <= sum_next_s;
                m_count_r <= count_next_s;
            end else if (m_valid_r && bus.m_ready) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    // Sample history; stale entries after clear are never read before rewrite
    always_ff @(posedge clk) begin
        if (accept_s) begin
            buf_r[wr_ptr_r] <= bus.s_data;
        end
    end

    assign bus.s_ready = s_ready_s;
    assign bus.m_valid = m_valid_r;
    assign bus.m_sum   = m_sum_r;
    assign bus.m_count = m_count_r;
endmodule

// File: tb/tb_running_sum_window.sv
// Directed bench for running_sum_window at DEPTH=4 with hand-computed sums.
// Build with RSUM_PRIME_EN defined to exercise the primed-output variant.
module tb_running_sum_window;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   n_vec  = 0;
    int   n_miss = 0;

    running_sum_window_if #(.WIDTH(32), .DATA_W(16)) bus_if ();

    running_sum_window #(.WIDTH(32), .DATA_W(16), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Present a sample (or idle) for one edge, then settle 1 time unit past it
    task automatic step(input logic v, input int d);
        bus_if.s_valid = v;
        bus_if.s_data  = 16'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear          = 1'b1;
        bus_if.s_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
`ifdef RSUM_PRIME_EN
        int pe_sum [6] = '{0, 0, 0, 10, 14, 18};
        int pe_val [6] = '{0, 0, 0, 1, 1, 1};
`else
        int s2 [5] = '{10, 20, 30, 40, 50};
        int e2s[5] = '{10, 30, 60, 100, 140};
        int e2c[5] = '{1, 2, 3, 4, 4};
        int s3 [5] = '{-5, -5, -5, -5, 3};
        int e3s[5] = '{-5, -10, -15, -20, -12};
`endif
        rst_n          = 1'b0;
        clear          = 1'b0;
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = 16'd0;
        bus_if.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("rst_s_ready", 32'(bus_if.s_ready), 32'd1);
        chk_eq("rst_m_valid", 32'(bus_if.m_valid), 32'd0);
        chk_eq("rst_m_sum",   bus_if.m_sum,        32'd0);
        chk_eq("rst_m_count", bus_if.m_count,      32'd0);

`ifdef RSUM_PRIME_EN
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i + 1);
            chk_eq($sformatf("prime_valid_%0d", i), 32'(bus_if.m_valid), 32'(pe_val[i]));
            if (pe_val[i] != 0) begin
                chk_eq($sformatf("prime_sum_%0d", i),   bus_if.m_sum,   32'(pe_sum[i]));
                chk_eq($sformatf("prime_count_%0d", i), bus_if.m_count, 32'd4);
            end
        end
        bus_if.s_valid = 1'b0;
`else
        // Ascending stream, wraps once past the window
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s2[i]);
            chk_eq($sformatf("asc_valid_%0d", i), 32'(bus_if.m_valid), 32'd1);
            chk_eq($sformatf("asc_sum_%0d", i),   bus_if.m_sum,        32'(e2s[i]));
            chk_eq($sformatf("asc_count_%0d", i), bus_if.m_count,      32'(e2c[i]));
        end
        pulse_clear();
        chk_eq("clr1_m_valid", 32'(bus_if.m_valid), 32'd0);

        // Negative samples, sign extension and oldest-sample subtraction
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s3[i]);
            chk_eq($sformatf("neg_sum_%0d", i),   bus_if.m_sum,   32'(e3s[i]));
            chk_eq($sformatf("neg_count_%0d", i), bus_if.m_count, 32'(e2c[i]));
        end
        pulse_clear();

        // Backpressure: first pair held for 3 cycles, pending sample waits
        bus_if.m_ready = 1'b0;
        step(1'b1, 1);
        chk_eq("bp_first_sum", bus_if.m_sum, 32'd1);
        bus_if.s_data = 16'd2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_eq($sformatf("bp_valid_%0d", i), 32'(bus_if.m_valid), 32'd1);
            chk_eq($sformatf("bp_sum_%0d", i),   bus_if.m_sum,        32'd1);
            chk_eq($sformatf("bp_count_%0d", i), bus_if.m_count,      32'd1);
            chk_eq($sformatf("bp_ready_%0d", i), 32'(bus_if.s_ready), 32'd0);
        end
        bus_if.m_ready = 1'b1;
        step(1'b1, 2);
        chk_eq("bp_rel_sum",   bus_if.m_sum,   32'd3);
        chk_eq("bp_rel_count", bus_if.m_count, 32'd2);
        step(1'b0, 0);
        chk_eq("bp_drain_valid", 32'(bus_if.m_valid), 32'd0);
        pulse_clear();

        // clear beats a simultaneous sample
        for (int i = 0; i < 3; i++) begin
            step(1'b1, i + 1);
        end
        chk_eq("pre_clr_sum", bus_if.m_sum, 32'd6);
        clear          = 1'b1;
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 16'd99;
        #1;
        chk_eq("clr_s_ready", 32'(bus_if.s_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk_eq("clr_m_valid", 32'(bus_if.m_valid), 32'd0);
        step(1'b1, 7);
        chk_eq("post_clr_valid", 32'(bus_if.m_valid), 32'd1);
        chk_eq("post_clr_sum",   bus_if.m_sum,        32'd7);
        chk_eq("post_clr_count", bus_if.m_count,      32'd1);

        // Asynchronous reset mid-stream
        step(1'b1, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_m_valid", 32'(bus_if.m_valid), 32'd0);
        chk_eq("arst_m_sum",   bus_if.m_sum,        32'd0);
        chk_eq("arst_m_count", bus_if.m_count,      32'd0);
        bus_if.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5);
        chk_eq("arst_next_sum",   bus_if.m_sum,   32'd5);
        chk_eq("arst_next_count", bus_if.m_count, 32'd1);
        bus_if.s_valid = 1'b0;
`endif
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
